// File: rtl/key_event_poller_pkg.sv
// Shared definitions for the key event poller: FSM states, PIO register
// addresses and the Avalon-MM data bus width.
package key_event_poller_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_EDGE   = 3'd1,
        EDGE_WAIT = 3'd2,
        WR_CLR    = 3'd3,
        RD_LVL    = 3'd4,
        LVL_WAIT  = 3'd5,
        EMIT      = 3'd6
    } state_e;

endpackage

// File: rtl/key_event_poller_poll_interval_counter.sv
// Poll interval down-counter.
// Counts POLL_CYCLES-1 down to 0 while run is high; reloads to POLL_CYCLES-1
// whenever run is low or the count has reached 0 (the expiry cycle).
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   run         - decrement enable (poller idle and polling enabled)
//   expired_c   - count is 0 (combinational from the count register)
module poll_interval_counter #(
    parameter int unsigned POLL_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Decrement while running; otherwise (or on expiry) sit at the reload value.
    always_comb begin
        count_d = RELOAD;
        if (run && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/key_event_poller.sv
// Avalon-MM initiator that polls a push-button PIO: reads edge capture,
// clears it when non-zero, reads the live level and emits one valid/ready event.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   enable            - allows new polls to start
//   avm_*             - Avalon-MM initiator towards the key PIO
//   evt_valid/ready   - event handshake; evt_edges/evt_level are the payload
//   busy              - high whenever a poll sequence is in progress
module key_event_poller
    import key_event_poller_pkg::*;
#(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned POLL_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [BUS_W-1:0]  avm_writedata,
    input  logic [BUS_W-1:0]  avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [WIDTH-1:0]  evt_edges,
    output logic [WIDTH-1:0]  evt_level,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [1:0]       address_q, address_d;
    logic             cs_q, cs_d;
    logic             write_n_q, write_n_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             busy_q, busy_d;

    logic             run_c;
    logic             expired_c;
    logic [WIDTH-1:0] rd_bits_c;
    logic             unused_rdata;

    assign rd_bits_c    = avm_readdata[WIDTH-1:0];
    // Only the key bits of readdata matter; the rest is ignored on purpose.
    assign unused_rdata = ^avm_readdata;

    assign run_c = (state_q == IDLE) && enable;

    poll_interval_counter #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_interval (
        .clk       (clk),
        .reset     (reset),
        .run       (run_c),
        .expired_c (expired_c)
    );

    // Next state and payload capture; bus/event outputs are derived from the
    // next state so they are registered together with it.
    always_comb begin
        state_d = state_q;
        edges_d = edges_q;
        level_d = level_q;
        case (state_q)
            IDLE:      if (run_c && expired_c) state_d = RD_EDGE;
            RD_EDGE:   state_d = EDGE_WAIT;
            EDGE_WAIT: begin
                if (rd_bits_c == '0) begin
                    state_d = IDLE;
                end else begin
                    edges_d = rd_bits_c;
                    state_d = WR_CLR;
                end
            end
            WR_CLR:    state_d = RD_LVL;
            RD_LVL:    state_d = LVL_WAIT;
            LVL_WAIT: begin
                level_d = rd_bits_c;
                state_d = EMIT;
            end
            EMIT:      if (evt_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        cs_d      = (state_d == RD_EDGE) || (state_d == WR_CLR) || (state_d == RD_LVL);
        write_n_d = (state_d != WR_CLR);
        address_d = ((state_d == RD_EDGE) || (state_d == WR_CLR)) ? ADDR_EDGE : ADDR_DATA;
        valid_d   = (state_d == EMIT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= ADDR_DATA;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            valid_q   <= 1'b0;
            edges_q   <= '0;
            level_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            valid_q   <= valid_d;
            edges_q   <= edges_d;
            level_q   <= level_d;
            busy_q    <= busy_d;
        end
    end

    assign avm_address    = address_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = BUS_W'(0);
    assign evt_valid      = valid_q;
    assign evt_edges      = edges_q;
    assign evt_level      = level_q;
    assign busy           = busy_q;

endmodule
